// File: rtl/key_press_classifier_pkg.sv
// Shared types and constants for the calculator memory-key front-end.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    LONG_WAIT = 2'd2
  } key_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int DEFAULT_LONG_CYCLES     = 50_000_000; // 1 s at 50 MHz

  localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_press_classifier_if.sv
// Key inputs and memory-command outputs between the board and the calculator memory logic.
interface key_press_classifier_if;

  logic [1:0] key;
  logic       save_pulse;
  logic       clear_pulse;
  logic       read_active;
  logic       read_pulse;
  logic       key0_held;

  modport master (
    output key,
    input  save_pulse,
    input  clear_pulse,
    input  read_active,
    input  read_pulse,
    input  key0_held
  );

  modport slave (
    input  key,
    output save_pulse,
    output clear_pulse,
    output read_active,
    output read_pulse,
    output key0_held
  );

endinterface

// File: rtl/key_press_classifier_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low push-button.
module key_debouncer
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_debounced
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic            RELEASED = ~KEY_PRESSED;

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic          r_sync1;
  logic          r_sync2;
  logic          r_debounced;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= RELEASED;
      r_sync2     <= RELEASED;
      r_debounced <= RELEASED;
      r_cnt       <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      // Count only an unbroken run of disagreement; any bounce restarts it.
      if (r_sync2 != r_debounced) begin
        if (r_cnt == CNT_LAST) begin
          r_debounced <= r_sync2;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_debounced = r_debounced;

endmodule

// File: rtl/key_press_classifier.sv
// Classifies key[0] into save (short) / clear (long) commands and key[1] into memory-read.
//
// state     | meaning
// IDLE      | key[0] released, waiting for a press
// HOLD      | key[0] pressed, timing the hold; release here means save
// LONG_WAIT | clear already issued, waiting for release without another pulse
module key_press_classifier
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  key_press_classifier_if.slave   bus
);

  localparam int            HW        = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  generate
    if (LONG_CYCLES < 2) begin : g_bad_long
      $error("key_press_classifier: LONG_CYCLES must be >= 2");
    end
  endgenerate

  logic [1:0] w_debounced;
  logic       w_pressed0;
  logic       w_pressed1;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb0 (
    .clk         (clk),
    .rst         (rst),
    .i_key       (bus.key[0]),
    .o_debounced (w_debounced[0])
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb1 (
    .clk         (clk),
    .rst         (rst),
    .i_key       (bus.key[1]),
    .o_debounced (w_debounced[1])
  );

  assign w_pressed0 = (w_debounced[0] == KEY_PRESSED);
  assign w_pressed1 = (w_debounced[1] == KEY_PRESSED);

  key_state_t    r_state;
  logic [HW-1:0] r_hold_cnt;
  logic          r_save_pulse;
  logic          r_clear_pulse;
  logic          r_key0_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_hold_cnt    <= '0;
      r_save_pulse  <= 1'b0;
      r_clear_pulse <= 1'b0;
      r_key0_held   <= 1'b0;
    end else begin
      r_save_pulse  <= 1'b0;
      r_clear_pulse <= 1'b0;
      r_key0_held   <= w_pressed0;
      case (r_state)
        IDLE: begin
          if (w_pressed0) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!w_pressed0) begin
            r_save_pulse <= 1'b1;
            r_state      <= IDLE;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_clear_pulse <= 1'b1;
            r_state       <= LONG_WAIT;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        LONG_WAIT: begin
          if (!w_pressed0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // key[1] has no timing classes; read_active doubles as the edge detector's delayed copy.
  logic r_read_active;
  logic r_read_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_active <= 1'b0;
      r_read_pulse  <= 1'b0;
    end else begin
      r_read_active <= w_pressed1;
      r_read_pulse  <= w_pressed1 & ~r_read_active;
    end
  end

  assign bus.save_pulse  = r_save_pulse;
  assign bus.clear_pulse = r_clear_pulse;
  assign bus.key0_held   = r_key0_held;
  assign bus.read_active = r_read_active;
  assign bus.read_pulse  = r_read_pulse;

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: directed plan plus random key activity against a window-based model.
module tb_key_press_classifier;
  import key_pkg::*;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst;

  key_press_classifier_if bus_if ();

  key_press_classifier #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a key's debounced level flips once the synchronised
  // level has disagreed with it for the last DB samples in a row.
  int            cyc = 0;
  logic [1:0]    m_s1, m_s2, m_deb;
  logic [DB-1:0] m_hist [2];
  int            m_len;
  logic          e_save, e_clear, e_held, e_ract, e_rpulse;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11;
      m_hist[0] = '1; m_hist[1] = '1;
      m_len = 0;
      e_save = 0; e_clear = 0; e_held = 0; e_ract = 0; e_rpulse = 0;
    end else begin
      logic p0, p1;
      p0 = !m_deb[0];
      p1 = !m_deb[1];
      e_rpulse = p1 && !e_ract;
      e_ract   = p1;
      e_held   = p0;
      if (p0) begin
        m_len++;
        e_clear = (m_len == LONG + 1);
        e_save  = 1'b0;
      end else begin
        e_save  = (m_len >= 1) && (m_len <= LONG);
        e_clear = 1'b0;
        m_len   = 0;
      end
      for (int k = 0; k < 2; k++) begin
        m_hist[k] = {m_hist[k][DB-2:0], m_s2[k]};
        if (m_hist[k] == {DB{~m_deb[k]}}) m_deb[k] = ~m_deb[k];
      end
      m_s2 = m_s1;
      m_s1 = bus_if.key;
    end
  end

  logic chk_en = 1'b0;
  logic prev_held = 1'b0;
  int n_save, n_clear, n_rpulse, n_ract, n_held;
  int t_held, t_clear, t_read;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("save_pulse",  bus_if.save_pulse,  e_save);
      check_eq("clear_pulse", bus_if.clear_pulse, e_clear);
      check_eq("key0_held",   bus_if.key0_held,   e_held);
      check_eq("read_active", bus_if.read_active, e_ract);
      check_eq("read_pulse",  bus_if.read_pulse,  e_rpulse);
      if (bus_if.key0_held && !prev_held) t_held = cyc;
      prev_held = bus_if.key0_held;
      if (bus_if.key0_held)   n_held++;
      if (bus_if.save_pulse)  n_save++;
      if (bus_if.clear_pulse) begin n_clear++; t_clear = cyc; end
      if (bus_if.read_pulse)  begin n_rpulse++; t_read = cyc; end
      if (bus_if.read_active) n_ract++;
    end
  end

  task automatic clr_stats();
    n_save = 0; n_clear = 0; n_rpulse = 0; n_ract = 0; n_held = 0;
    t_held = -1000; t_clear = -1000; t_read = -1000;
  endtask

  task automatic drive(input logic [1:0] k, input int n);
    bus_if.key = k;
    repeat (n) @(negedge clk);
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    bus_if.key = 2'b11;
    clr_stats();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // idle after reset
    clr_stats();
    drive(2'b11, 100);
    check_eq("idle_held",   n_held, 0);
    check_eq("idle_pulses", n_save + n_clear + n_rpulse, 0);
    check_eq("idle_read",   n_ract, 0);

    // short press
    clr_stats();
    t0 = cyc;
    drive(2'b10, 10);
    drive(2'b11, 30);
    check_eq("short_held_lat", t_held - t0, 7);
    check_eq("short_save_cnt", n_save, 1);
    check_eq("short_clear_cnt", n_clear, 0);

    // long press
    clr_stats();
    t0 = cyc;
    drive(2'b10, 40);
    drive(2'b11, 30);
    check_eq("long_held_lat",  t_held - t0, 7);
    check_eq("long_clear_cnt", n_clear, 1);
    check_eq("long_clear_lat", t_clear - t_held, 20);
    check_eq("long_save_cnt",  n_save, 0);
    check_eq("long_fsm_idle",  32'(dut.r_state), 32'(IDLE));

    // bounce shorter than the debounce window
    clr_stats();
    drive(2'b10, 3);
    drive(2'b11, 3);
    drive(2'b10, 3);
    drive(2'b11, 30);
    check_eq("bounce_held",   n_held, 0);
    check_eq("bounce_pulses", n_save + n_clear, 0);

    // read key
    clr_stats();
    t0 = cyc;
    drive(2'b01, 15);
    drive(2'b11, 30);
    check_eq("read_pulse_cnt", n_rpulse, 1);
    check_eq("read_pulse_lat", t_read - t0, 7);
    check_eq("read_active_len", n_ract, 15);
    check_eq("read_no_key0", n_held + n_save + n_clear, 0);

    // reset mid-hold, key still held afterwards
    clr_stats();
    drive(2'b10, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    drive(2'b10, 30);
    drive(2'b11, 30);
    check_eq("rst_held_lat",  t_held - t0, 7);
    check_eq("rst_clear_cnt", n_clear, 1);
    check_eq("rst_clear_lat", t_clear - t_held, 20);
    check_eq("rst_save_cnt",  n_save, 0);

    // random activity, occasional resets
    repeat (80) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 40)));
    end
    drive(2'b11, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
